multicycle_control: RTL and testbench

Multi-cycle control FSM for the mini-cpu datapath. It decodes the opcode and funct3 fields from the instruction register, then sequences fetch, decode, execute, memory and writeback for the supported instructions: R-type ALU, `ld`, `sd` and `beq`. It steers the ALU operand muxes to select PC, register, constant 4, the S-type memory immediate (`imm_mem`) or the SB-type branch immediate (`imm_branch`). It also owns the single shared memory port's request handshake, a wait watchdog and the trap state for illegal opcodes.

---
 rtl/mini_cpu_ctrl_pkg.sv | 57 +++++
 rtl/ctrl_wait_timer.sv | 29 ++
 rtl/multicycle_control.sv | 179 +++++++++++++++++
 tb/tb_multicycle_control.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mini_cpu_ctrl_pkg.sv
// Shared types and constants for the mini-cpu multi-cycle control unit.
// Operand-select, ALU-op and trap-cause encodings match the datapath muxes.
package mini_cpu_ctrl_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_MEM_ADDR,
      S_MEM_READ,
      S_MEM_WB,
      S_MEM_WRITE,
      S_EXEC_R,
      S_ALU_WB,
      S_BRANCH,
      S_TRAP
   } state_t;

   typedef enum logic [1:0] {
      SRC_A_PC     = 2'd0,
      SRC_A_OLD_PC = 2'd1,
      SRC_A_REG_A  = 2'd2
   } alu_src_a_t;

   typedef enum logic [1:0] {
      SRC_B_REG_B      = 2'd0,
      SRC_B_FOUR       = 2'd1,
      SRC_B_IMM_MEM    = 2'd2,
      SRC_B_IMM_BRANCH = 2'd3
   } alu_src_b_t;

   typedef enum logic [1:0] {
      ALU_ADD   = 2'd0,
      ALU_SUB   = 2'd1,
      ALU_FUNCT = 2'd2
   } alu_op_t;

   typedef enum logic [1:0] {
      CAUSE_NONE    = 2'b00,
      CAUSE_ILLEGAL = 2'b01,
      CAUSE_TIMEOUT = 2'b10
   } trap_cause_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [2:0] F3_D   = 3'b011;
   localparam logic [2:0] F3_BEQ = 3'b000;

   // States that hold a request on the shared memory port.
   function automatic logic is_wait_state(input state_t s);
      return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
   endfunction

endpackage

// File: rtl/ctrl_wait_timer.sv
// Memory-wait watchdog: counts stalled request cycles and flags the last
// permitted one so the FSM can divert to the timeout trap.
module ctrl_wait_timer #(
   parameter int MAX_WAIT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic count_en,
   output logic expired
);

   localparam int CNT_W = $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_WAIT - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (clear)
         cnt <= '0;
      else if (count_en)
         cnt <= cnt + CNT_W'(1);
   end

   assign expired = count_en && (cnt == LIMIT);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the mini-cpu: sequences ld/sd/R-type/beq,
// owns the memory request handshake, the wait watchdog and the trap state.
module multicycle_control #(
   parameter int MAX_WAIT = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       mem_ready,
   input  logic       alu_zero,
   output logic       mem_req,
   output logic       mem_we,
   output logic       i_or_d,
   output logic       ir_write,
   output logic       mdr_write,
   output logic       pc_write,
   output logic       pc_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic       reg_write,
   output logic       wb_sel,
   output logic       trap,
   output logic [1:0] trap_cause
);

   import mini_cpu_ctrl_pkg::*;

   state_t      state, state_next;
   trap_cause_t cause, cause_next;
   logic        wd_clear, wd_count_en, wd_expired;

   // Counter restarts whenever a request state is freshly entered.
   assign wd_clear    = is_wait_state(state_next) && (state_next != state);
   assign wd_count_en = is_wait_state(state) && !mem_ready;

   ctrl_wait_timer #(
      .MAX_WAIT (MAX_WAIT)
   ) u_wait_timer (
      .clk      (clk),
      .rst      (rst),
      .clear    (wd_clear),
      .count_en (wd_count_en),
      .expired  (wd_expired)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         cause <= CAUSE_NONE;
      end else begin
         state <= state_next;
         cause <= cause_next;
      end
   end

   always_comb begin
      state_next = state;
      cause_next = cause;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      i_or_d     = 1'b0;
      ir_write   = 1'b0;
      mdr_write  = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      alu_src_a  = SRC_A_PC;
      alu_src_b  = SRC_B_REG_B;
      alu_op     = ALU_ADD;
      reg_write  = 1'b0;
      wb_sel     = 1'b0;
      trap       = 1'b0;
      trap_cause = CAUSE_NONE;

      case (state)
         S_IDLE: state_next = S_FETCH;

         S_FETCH: begin
            mem_req   = 1'b1;
            alu_src_a = SRC_A_PC;
            alu_src_b = SRC_B_FOUR;
            alu_op    = ALU_ADD;
            if (mem_ready) begin
               ir_write   = 1'b1;
               pc_write   = 1'b1;
               state_next = S_DECODE;
            end else if (wd_expired) begin
               state_next = S_TRAP;
               cause_next = CAUSE_TIMEOUT;
            end
         end

         S_DECODE: begin
            // Branch target is computed speculatively into ALUOut here.
            alu_src_a = SRC_A_OLD_PC;
            alu_src_b = SRC_B_IMM_BRANCH;
            alu_op    = ALU_ADD;
            if (((opcode == OP_LOAD) || (opcode == OP_STORE)) && (funct3 == F3_D))
               state_next = S_MEM_ADDR;
            else if (opcode == OP_RTYPE)
               state_next = S_EXEC_R;
            else if ((opcode == OP_BRANCH) && (funct3 == F3_BEQ))
               state_next = S_BRANCH;
            else begin
               state_next = S_TRAP;
               cause_next = CAUSE_ILLEGAL;
            end
         end

         S_MEM_ADDR: begin
            alu_src_a  = SRC_A_REG_A;
            alu_src_b  = SRC_B_IMM_MEM;
            alu_op     = ALU_ADD;
            state_next = opcode[5] ? S_MEM_WRITE : S_MEM_READ;
         end

         S_MEM_READ: begin
            mem_req = 1'b1;
            i_or_d  = 1'b1;
            if (mem_ready) begin
               mdr_write  = 1'b1;
               state_next = S_MEM_WB;
            end else if (wd_expired) begin
               state_next = S_TRAP;
               cause_next = CAUSE_TIMEOUT;
            end
         end

         S_MEM_WB: begin
            reg_write  = 1'b1;
            wb_sel     = 1'b1;
            state_next = S_FETCH;
         end

         S_MEM_WRITE: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            i_or_d  = 1'b1;
            if (mem_ready)
               state_next = S_FETCH;
            else if (wd_expired) begin
               state_next = S_TRAP;
               cause_next = CAUSE_TIMEOUT;
            end
         end

         S_EXEC_R: begin
            alu_src_a  = SRC_A_REG_A;
            alu_src_b  = SRC_B_REG_B;
            alu_op     = ALU_FUNCT;
            state_next = S_ALU_WB;
         end

         S_ALU_WB: begin
            reg_write  = 1'b1;
            wb_sel     = 1'b0;
            state_next = S_FETCH;
         end

         S_BRANCH: begin
            alu_src_a  = SRC_A_REG_A;
            alu_src_b  = SRC_B_REG_B;
            alu_op     = ALU_SUB;
            pc_write   = alu_zero;
            pc_src     = 1'b1;
            state_next = S_FETCH;
         end

         S_TRAP: begin
            trap       = 1'b1;
            trap_cause = cause;
         end

         default: state_next = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks ld/beq/R/sd, memory stalls,
// watchdog timeout, illegal-opcode trap and asynchronous reset.
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       mem_ready;
   logic       alu_zero;
   logic       mem_req, mem_we, i_or_d, ir_write, mdr_write, pc_write, pc_src;
   logic [1:0] alu_src_a, alu_src_b, alu_op;
   logic       reg_write, wb_sel, trap;
   logic [1:0] trap_cause;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   multicycle_control #(.MAX_WAIT(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .opcode     (opcode),
      .funct3     (funct3),
      .mem_ready  (mem_ready),
      .alu_zero   (alu_zero),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .i_or_d     (i_or_d),
      .ir_write   (ir_write),
      .mdr_write  (mdr_write),
      .pc_write   (pc_write),
      .pc_src     (pc_src),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .alu_op     (alu_op),
      .reg_write  (reg_write),
      .wb_sel     (wb_sel),
      .trap       (trap),
      .trap_cause (trap_cause)
   );

   // Output vector: mem_req we i_or_d ir_wr mdr_wr pc_wr pc_src a b op reg_wr wb_sel trap cause
   logic [17:0] outs;
   assign outs = {mem_req, mem_we, i_or_d, ir_write, mdr_write, pc_write, pc_src,
                  alu_src_a, alu_src_b, alu_op, reg_write, wb_sel, trap, trap_cause};

   function automatic logic [17:0] ov(input logic mr, we, iod, irw, mdrw, pcw, pcs,
                                      input logic [1:0] a, b, op,
                                      input logic rw, wbs, tr,
                                      input logic [1:0] c);
      return {mr, we, iod, irw, mdrw, pcw, pcs, a, b, op, rw, wbs, tr, c};
   endfunction

   // A: PC=0 OLD_PC=1 REG_A=2; B: REG_B=0 FOUR=1 IMM_MEM=2 IMM_BRANCH=3; op: ADD=0 SUB=1 FUNCT=2
   localparam logic [17:0] O_IDLE      = ov(0,0,0,0,0,0,0, 2'd0,2'd0,2'd0, 0,0,0, 2'b00);
   localparam logic [17:0] O_FETCH_W   = ov(1,0,0,0,0,0,0, 2'd0,2'd1,2'd0, 0,0,0, 2'b00);
   localparam logic [17:0] O_FETCH_R   = ov(1,0,0,1,0,1,0, 2'd0,2'd1,2'd0, 0,0,0, 2'b00);
   localparam logic [17:0] O_DECODE    = ov(0,0,0,0,0,0,0, 2'd1,2'd3,2'd0, 0,0,0, 2'b00);
   localparam logic [17:0] O_MEM_ADDR  = ov(0,0,0,0,0,0,0, 2'd2,2'd2,2'd0, 0,0,0, 2'b00);
   localparam logic [17:0] O_MRD_W     = ov(1,0,1,0,0,0,0, 2'd0,2'd0,2'd0, 0,0,0, 2'b00);
   localparam logic [17:0] O_MRD_R     = ov(1,0,1,0,1,0,0, 2'd0,2'd0,2'd0, 0,0,0, 2'b00);
   localparam logic [17:0] O_MEM_WB    = ov(0,0,0,0,0,0,0, 2'd0,2'd0,2'd0, 1,1,0, 2'b00);
   localparam logic [17:0] O_MEM_WRITE = ov(1,1,1,0,0,0,0, 2'd0,2'd0,2'd0, 0,0,0, 2'b00);
   localparam logic [17:0] O_EXEC_R    = ov(0,0,0,0,0,0,0, 2'd2,2'd0,2'd2, 0,0,0, 2'b00);
   localparam logic [17:0] O_ALU_WB    = ov(0,0,0,0,0,0,0, 2'd0,2'd0,2'd0, 1,0,0, 2'b00);
   localparam logic [17:0] O_BR_TAKEN  = ov(0,0,0,0,0,1,1, 2'd2,2'd0,2'd1, 0,0,0, 2'b00);
   localparam logic [17:0] O_BR_NOT    = ov(0,0,0,0,0,0,1, 2'd2,2'd0,2'd1, 0,0,0, 2'b00);
   localparam logic [17:0] O_TRAP_ILL  = ov(0,0,0,0,0,0,0, 2'd0,2'd0,2'd0, 0,0,1, 2'b01);
   localparam logic [17:0] O_TRAP_TMO  = ov(0,0,0,0,0,0,0, 2'd0,2'd0,2'd0, 0,0,1, 2'b10);

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [17:0] expv);
      #1;
      checks++;
      assert (outs === expv)
      else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, outs, expv);
      end
   endtask

   task automatic set_instr(input logic [6:0] op, input logic [2:0] f3);
      opcode = op;
      funct3 = f3;
   endtask

   initial begin
      rst = 1'b1; opcode = '0; funct3 = '0; mem_ready = 1'b0; alu_zero = 1'b0;
      repeat (2) cyc();
      chk("reset_idle", O_IDLE);
      rst = 1'b0;
      chk("idle_after_release", O_IDLE);

      // ld, no stalls: 5 cycles
      cyc(); set_instr(7'b0000011, 3'b011); mem_ready = 1'b1;
      chk("ld_fetch", O_FETCH_R);
      cyc(); chk("ld_decode", O_DECODE);
      cyc(); chk("ld_mem_addr", O_MEM_ADDR);
      cyc(); chk("ld_mem_read", O_MRD_R);
      cyc(); chk("ld_mem_wb", O_MEM_WB);

      // beq taken, including Mealy response to alu_zero
      cyc(); set_instr(7'b1100011, 3'b000); alu_zero = 1'b1;
      chk("beq_t_fetch", O_FETCH_R);
      cyc(); chk("beq_t_decode", O_DECODE);
      cyc(); chk("beq_t_branch", O_BR_TAKEN);
      alu_zero = 1'b0;
      chk("beq_mealy_drop", O_BR_NOT);

      // beq not taken
      cyc(); chk("beq_n_fetch", O_FETCH_R);
      cyc(); chk("beq_n_decode", O_DECODE);
      cyc(); chk("beq_n_branch", O_BR_NOT);

      // R-type
      cyc(); set_instr(7'b0110011, 3'b111);
      chk("r_fetch", O_FETCH_R);
      cyc(); chk("r_decode", O_DECODE);
      cyc(); chk("r_exec", O_EXEC_R);
      cyc(); chk("r_alu_wb", O_ALU_WB);

      // sd with 3 stall cycles; ready lands on the watchdog limit and wins
      cyc(); set_instr(7'b0100011, 3'b011);
      chk("sd_fetch", O_FETCH_R);
      cyc(); chk("sd_decode", O_DECODE);
      cyc(); chk("sd_mem_addr", O_MEM_ADDR);
      cyc(); mem_ready = 1'b0;
      chk("sd_write_w1", O_MEM_WRITE);
      cyc(); chk("sd_write_w2", O_MEM_WRITE);
      cyc(); chk("sd_write_w3", O_MEM_WRITE);
      cyc(); mem_ready = 1'b1;
      chk("sd_write_done", O_MEM_WRITE);

      // ld with a stall in MEM_READ, then asynchronous reset mid-cycle
      cyc(); set_instr(7'b0000011, 3'b011);
      chk("ld2_fetch", O_FETCH_R);
      cyc(); chk("ld2_decode", O_DECODE);
      cyc(); chk("ld2_mem_addr", O_MEM_ADDR);
      cyc(); mem_ready = 1'b0;
      chk("ld2_read_wait", O_MRD_W);
      #2 rst = 1'b1;
      chk("async_rst_drop", O_IDLE);
      cyc(); chk("rst_held_idle", O_IDLE);
      rst = 1'b0;
      chk("rst_release_idle", O_IDLE);

      // Watchdog timeout in FETCH (MAX_WAIT=4)
      cyc(); chk("tmo_fetch_c1", O_FETCH_W);
      cyc(); chk("tmo_fetch_c2", O_FETCH_W);
      cyc(); chk("tmo_fetch_c3", O_FETCH_W);
      cyc(); chk("tmo_fetch_c4", O_FETCH_W);
      cyc(); chk("tmo_trap_c5", O_TRAP_TMO);
      mem_ready = 1'b1;
      cyc(); chk("tmo_trap_hold", O_TRAP_TMO);

      rst = 1'b1;
      cyc(); rst = 1'b0;
      chk("tmo_cleared", O_IDLE);

      // Ready on the 4th FETCH cycle beats the timeout; then illegal opcode
      cyc(); mem_ready = 1'b0; set_instr(7'b1111111, 3'b000);
      chk("late_fetch_c1", O_FETCH_W);
      cyc(); chk("late_fetch_c2", O_FETCH_W);
      cyc(); chk("late_fetch_c3", O_FETCH_W);
      cyc(); mem_ready = 1'b1;
      chk("late_fetch_c4", O_FETCH_R);
      cyc(); chk("ill_decode", O_DECODE);
      for (int i = 0; i < 100; i++) begin
         cyc();
         mem_ready = i[0];
         alu_zero  = i[1];
         chk($sformatf("ill_trap_%0d", i), O_TRAP_ILL);
      end

      rst = 1'b1;
      chk("final_rst", O_IDLE);
      cyc(); rst = 1'b0;
      cyc(); mem_ready = 1'b0;
      chk("final_fetch", O_FETCH_W);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
